hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 16: number of architectural registers tracked.
REQ-002 Parameter REG_AW, default 4: register address width; NUM_REGS SHALL be <= 2**REG_AW.
REQ-003 Parameter WB_LAT, default 3, range 1..8: cycles from accepted issue to write-back completion.
REQ-004 Parameter FWD_MASK, WB_LAT bits, default 0: bit k set means a producer at stage k is forwardable and SHALL NOT cause a stall.
REQ-005 Parameter FLUSH_DEPTH, default 1, range 0..WB_LAT: number of youngest stages squashed by flush.
REQ-006 Parameter ZERO_REG_EN, default 1: register 0 is hardwired, never tracked and never hazardous.
REQ-007 One clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-008 clk  in  1  global clock.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 issue_valid  in  1  decode stage presents an instruction.
REQ-011 issue_rs, issue_rt, issue_rd  in  REG_AW each  source 1, source 2 and destination register.
REQ-012 uses_rs, uses_rt  in  1 each  instruction reads the corresponding source.
REQ-013 rd_we  in  1  instruction writes issue_rd.
REQ-014 flush  in  1  squash the youngest FLUSH_DEPTH in-flight stages (taken branch, call or return).
REQ-015 stall  out  1  combinational; decode SHALL hold and insert a bubble.
REQ-016 issue_accept  out  1  combinational; equals issue_valid & ~stall & ~flush.
REQ-017 busy_vec  out  NUM_REGS  combinational; bit r is the OR of all pending bits of register r.
REQ-018 stall_count  out  16  registered; saturating count of stalled cycles.

Function
REQ-019 State per register r: a WB_LAT-bit pending vector pend[r]; bit k set means a write to r was accepted k+1 cycles ago.
REQ-020 Every clock edge, each pend[r] SHALL shift up one position; bit WB_LAT-1 drops out, meaning write-back completed.
REQ-021 On an edge where issue_accept=1, rd_we=1, and issue_rd is not zero-with-ZERO_REG_EN, pend[issue_rd] bit 0 SHALL be set after the shift.
REQ-022 stall = issue_valid & ((uses_rs & |(pend[issue_rs] & ~FWD_MASK)) | (uses_rt & |(pend[issue_rt] & ~FWD_MASK))); register-0 sources SHALL never stall when ZERO_REG_EN=1.
REQ-023 On flush, bits 0..FLUSH_DEPTH-1 of every pend[r] SHALL be cleared before the shift; older stages SHALL be unaffected.
REQ-024 Simultaneous flush and issue_valid: issue_accept=0 and nothing is recorded.
REQ-025 Multiple outstanding writes to one register (WAW) SHALL occupy separate bits; retiring or flushing one SHALL NOT clear another.
REQ-026 Source addresses >= NUM_REGS SHALL never stall; destination addresses >= NUM_REGS SHALL NOT be recorded.
REQ-027 stall_count SHALL increment on each edge where stall=1 and SHALL hold at 16'hFFFF.
REQ-028 Stalls SHALL NOT alter pend other than the normal shift, so a stalled instruction is eventually released.

Reset
REQ-029 While rst=1, all pend bits SHALL be 0, stall_count SHALL be 0, busy_vec SHALL be 0, and stall SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a clock edge; the first edge after release behaves as a fresh start.

Verification
REQ-031 WB_LAT=3, FWD_MASK=0: accept a write to r3 at edge 0, then hold a reader of r3 -> stall=1 in cycles 1-3, stall=0 and issue_accept=1 in cycle 4, stall_count=3.
REQ-032 WB_LAT=3, FWD_MASK=3'b001: write r5, then read r5 next cycle -> no stall in cycle 1; a reader presented in cycle 2 with only bit 1 set -> stall.
REQ-033 FLUSH_DEPTH=1: accept a write to r7, assert flush the next cycle -> busy_vec[7]=0 afterward; an older r7 write two stages deep survives and still stalls readers.
REQ-034 ZERO_REG_EN=1: write r0, then read r0 -> busy_vec=0 and stall=0 throughout.
REQ-035 Assert rst asynchronously while r2 and r9 are pending and stall_count=5 -> busy_vec=0, stall_count=0, and stall=0 before the next edge.
REQ-036 Hold a permanent hazard for 70000 cycles -> stall_count saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue request, flush, and the stall/accept/busy status returned.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned REG_AW   = 4
);
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rs;
  logic [REG_AW-1:0] issue_rt;
  logic [REG_AW-1:0] issue_rd;
  logic              uses_rs;
  logic              uses_rt;
  logic              rd_we;
  logic              flush;
  logic              stall;
  logic              issue_accept;
  logic [NUM_REGS-1:0] busy_vec;
  logic [15:0]       stall_count;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, uses_rs, uses_rt, rd_we, flush,
    input  stall, issue_accept, busy_vec, stall_count
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, uses_rs, uses_rt, rd_we, flush,
    output stall, issue_accept, busy_vec, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: one shift-register of in-flight writes per architectural register,
// raising a decode stall while a non-forwardable producer of a source is still in flight.
module hazard_scoreboard #(
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       REG_AW      = 4,
  parameter int unsigned       WB_LAT      = 3,
  parameter logic [WB_LAT-1:0] FWD_MASK    = '0,
  parameter int unsigned       FLUSH_DEPTH = 1,
  parameter bit                ZERO_REG_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  sb_io
);

  // Stages 0..FLUSH_DEPTH-1 hold the youngest writes, which a flush squashes.
  localparam logic [WB_LAT-1:0] FlushMask = WB_LAT'((64'd1 << FLUSH_DEPTH) - 64'd1);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] hit_rs;
  logic [NUM_REGS-1:0] hit_rt;
  logic                stall;
  logic                accept;
  logic                record;
  logic [15:0]         stall_count_q;
  logic [15:0]         stall_count_d;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    localparam bit Tracked = !(ZERO_REG_EN && (r == 0));
    logic [WB_LAT-1:0] pend_q;

    if (Tracked) begin : g_trk
      logic [WB_LAT-1:0] pend_d;

      always_comb begin
        pend_d    = pend_q & ~(sb_io.flush ? FlushMask : '0);
        pend_d    = pend_d << 1;
        pend_d[0] = record & (sb_io.issue_rd == REG_AW'(r));
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_q <= '0;
        end else begin
          pend_q <= pend_d;
        end
      end
    end else begin : g_zero
      assign pend_q = '0;
    end

    assign busy[r]   = |pend_q;
    // Out-of-range source addresses match no entry and therefore never stall.
    assign hit_rs[r] = (sb_io.issue_rs == REG_AW'(r)) & (|(pend_q & ~FWD_MASK));
    assign hit_rt[r] = (sb_io.issue_rt == REG_AW'(r)) & (|(pend_q & ~FWD_MASK));
  end

  assign stall  = sb_io.issue_valid & ((sb_io.uses_rs & (|hit_rs)) | (sb_io.uses_rt & (|hit_rt)));
  assign accept = sb_io.issue_valid & ~stall & ~sb_io.flush;
  assign record = accept & sb_io.rd_we;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign sb_io.stall        = stall;
  assign sb_io.issue_accept = accept;
  assign sb_io.busy_vec     = busy;
  assign sb_io.stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle, a monitor compares.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic rst_sat;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(12), .REG_AW(4)) m_if ();
  hazard_scoreboard_if #(.NUM_REGS(12), .REG_AW(4)) f_if ();
  hazard_scoreboard_if #(.NUM_REGS(4),  .REG_AW(2)) s_if ();

  // Forwarding variant sees exactly the same stimulus as the main instance.
  assign f_if.issue_valid = m_if.issue_valid;
  assign f_if.issue_rs    = m_if.issue_rs;
  assign f_if.issue_rt    = m_if.issue_rt;
  assign f_if.issue_rd    = m_if.issue_rd;
  assign f_if.uses_rs     = m_if.uses_rs;
  assign f_if.uses_rt     = m_if.uses_rt;
  assign f_if.rd_we       = m_if.rd_we;
  assign f_if.flush       = m_if.flush;

  hazard_scoreboard #(
    .NUM_REGS(12), .REG_AW(4), .WB_LAT(3), .FWD_MASK(3'b000), .FLUSH_DEPTH(1), .ZERO_REG_EN(1'b1)
  ) u_main (.clk(clk), .rst(rst), .sb_io(m_if));

  hazard_scoreboard #(
    .NUM_REGS(12), .REG_AW(4), .WB_LAT(3), .FWD_MASK(3'b001), .FLUSH_DEPTH(1), .ZERO_REG_EN(1'b1)
  ) u_fwd (.clk(clk), .rst(rst), .sb_io(f_if));

  hazard_scoreboard #(
    .NUM_REGS(4), .REG_AW(2), .WB_LAT(8), .FWD_MASK(8'h00), .FLUSH_DEPTH(1), .ZERO_REG_EN(1'b1)
  ) u_sat (.clk(clk), .rst(rst_sat), .sb_io(s_if));

  typedef struct {
    string       name;
    logic        stall;
    logic        acc;
    logic [11:0] busy;
    logic [15:0] cnt;
    bit          fchk;
    logic        fstall;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  bit   sat_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic urs, input logic urt,
                        input logic we, input logic fl);
    m_if.issue_valid = v;
    m_if.issue_rs    = rs;
    m_if.issue_rt    = rt;
    m_if.issue_rd    = rd;
    m_if.uses_rs     = urs;
    m_if.uses_rt     = urt;
    m_if.rd_we       = we;
    m_if.flush       = fl;
  endtask

  task automatic push_exp(input string nm, input logic es, input logic ea, input logic [11:0] eb,
                          input logic [15:0] ec, input bit fc, input logic efs);
    exp_t e;
    e.name   = nm;
    e.stall  = es;
    e.acc    = ea;
    e.busy   = eb;
    e.cnt    = ec;
    e.fchk   = fc;
    e.fstall = efs;
    exp_q.push_back(e);
  endtask

  // One cycle: apply inputs just after a rising edge, queue what the outputs must read.
  task automatic step(input string nm, input logic v, input logic [3:0] rs, input logic [3:0] rt,
                      input logic [3:0] rd, input logic urs, input logic urt, input logic we,
                      input logic fl, input logic es, input logic ea, input logic [11:0] eb,
                      input logic [15:0] ec, input bit fc, input logic efs);
    set_in(v, rs, rt, rd, urs, urt, we, fl);
    push_exp(nm, es, ea, eb, ec, fc, efs);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_stall"}, 32'(m_if.stall), 32'(mon_e.stall));
        check({mon_e.name, "_accept"}, 32'(m_if.issue_accept), 32'(mon_e.acc));
        check({mon_e.name, "_busy"}, 32'(m_if.busy_vec), 32'(mon_e.busy));
        check({mon_e.name, "_count"}, 32'(m_if.stall_count), 32'(mon_e.cnt));
        if (mon_e.fchk) begin
          check({mon_e.name, "_fwd_stall"}, 32'(f_if.stall), 32'(mon_e.fstall));
        end
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 16'd0, 0, 0);
    rst = 1'b0;

    // Write r3, then a held reader of r3 stalls three cycles.
    step("a0_wr3", 1, 0, 0, 3, 0, 0, 1, 0, 0, 1, 12'h000, 16'd0, 0, 0);
    step("a1_rd3", 1, 3, 0, 0, 1, 0, 0, 0, 1, 0, 12'h008, 16'd0, 0, 0);
    step("a2_rd3", 1, 3, 0, 0, 1, 0, 0, 0, 1, 0, 12'h008, 16'd1, 0, 0);
    step("a3_rd3", 1, 3, 0, 0, 1, 0, 0, 0, 1, 0, 12'h008, 16'd2, 0, 0);
    step("a4_rd3", 1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 12'h000, 16'd3, 0, 0);

    // Forwarding from stage 0 only.
    step("b0_wr5", 1, 0, 0, 5, 0, 0, 1, 0, 0, 1, 12'h000, 16'd3, 1, 0);
    step("b1_rd5", 1, 0, 5, 0, 0, 1, 0, 0, 1, 0, 12'h020, 16'd3, 1, 0);
    step("b2_rd5", 1, 0, 5, 0, 0, 1, 0, 0, 1, 0, 12'h020, 16'd4, 1, 1);
    step("b3_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h020, 16'd5, 1, 0);

    // Asynchronous reset while r2 and r9 are pending and the count is 5.
    step("e0_wr2", 1, 0, 0, 2, 0, 0, 1, 0, 0, 1, 12'h000, 16'd5, 0, 0);
    step("e1_wr9", 1, 0, 0, 9, 0, 0, 1, 0, 0, 1, 12'h004, 16'd5, 0, 0);
    step("e2_pend", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h204, 16'd5, 0, 0);
    set_in(1, 2, 0, 0, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    push_exp("e3_async_rst", 0, 1, 12'h000, 16'd0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("e4_fresh", 1, 2, 0, 0, 1, 0, 0, 0, 0, 1, 12'h000, 16'd0, 0, 0);

    // Flush squashes the younger of two r7 writes; the older one still stalls.
    step("c0_wr7", 1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 12'h000, 16'd0, 0, 0);
    step("c1_wr7", 1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 12'h080, 16'd0, 0, 0);
    step("c2_flush_wr9", 1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 12'h080, 16'd0, 0, 0);
    step("c3_rd7", 1, 7, 0, 0, 1, 0, 0, 0, 1, 0, 12'h080, 16'd0, 0, 0);
    step("c4_rd7", 1, 7, 0, 0, 1, 0, 0, 0, 0, 1, 12'h000, 16'd1, 0, 0);
    step("c5_wr7", 1, 0, 0, 7, 0, 0, 1, 0, 0, 1, 12'h000, 16'd1, 0, 0);
    step("c6_flush", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12'h080, 16'd1, 0, 0);
    step("c7_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 16'd1, 0, 0);

    // Register 0, out-of-range addresses, and the use-enable qualifiers.
    step("d0_wr0", 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 12'h000, 16'd1, 0, 0);
    step("d1_rd0", 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 12'h000, 16'd1, 0, 0);
    step("d2_wr13", 1, 0, 0, 13, 0, 0, 1, 0, 0, 1, 12'h000, 16'd1, 0, 0);
    step("d3_wr1", 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 12'h000, 16'd1, 0, 0);
    step("d4_rd13", 1, 13, 0, 0, 1, 0, 0, 0, 0, 1, 12'h002, 16'd1, 0, 0);
    step("d5_unused_rs", 1, 1, 2, 0, 0, 1, 0, 0, 0, 1, 12'h002, 16'd1, 0, 0);
    step("d6_rd1_rt", 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 12'h002, 16'd1, 0, 0);
    step("d7_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 16'd2, 0, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    wait (sat_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Self-dependent instruction held valid: one accept then eight stalls, repeating.
  initial begin : saturation
    rst_sat            = 1'b1;
    s_if.issue_valid   = 1'b1;
    s_if.issue_rs      = 2'd1;
    s_if.issue_rt      = 2'd0;
    s_if.issue_rd      = 2'd1;
    s_if.uses_rs       = 1'b1;
    s_if.uses_rt       = 1'b0;
    s_if.rd_we         = 1'b1;
    s_if.flush         = 1'b0;
    #2;
    rst_sat = 1'b0;
    repeat (9000) @(posedge clk);
    #1;
    check("sat_count_8000", 32'(s_if.stall_count), 32'd8000);
    repeat (9 * 8191 - 9000) @(posedge clk);
    #1;
    check("sat_count_65528", 32'(s_if.stall_count), 32'd65528);
    repeat (9) @(posedge clk);
    #1;
    check("sat_count_max", 32'(s_if.stall_count), 32'hFFFF);
    repeat (90) @(posedge clk);
    #1;
    check("sat_count_hold", 32'(s_if.stall_count), 32'hFFFF);
    sat_done = 1'b1;
  end

endmodule
